vga_text_console: RTL
=====================

VGA_TEXT_CONSOLE -- requirements
Module: vga_text_console

Interface
REQ-001 SHALL have port clk25mhz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: host character byte valid.
REQ-004 SHALL have port in_data, input, 8 bits: bit7 = emphasized attribute, bits6:0 = ASCII code.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-006 SHALL have port mem_we, output, 1 bit: write strobe to the character RAM write port.
REQ-007 SHALL have port mem_addr, output, 12 bits: character RAM cell address, row*80+col.
REQ-008 SHALL have port mem_wdata, output, 8 bits: character RAM cell data.
REQ-009 SHALL have port cursor_addr, output, 12 bits: current cursor cell, 0..2719.
REQ-010 SHALL have port busy, output, 1 bit: a clear-screen sweep is in progress.

Function
REQ-011 SHALL model an 80-column x 34-row grid, 2720 cells, addresses 0..2719.
REQ-012 SHALL implement FSM states IDLE and CLEAR.
REQ-013 SHALL drive in_ready=1 only in IDLE; transfer = in_valid && in_ready.
REQ-014 SHALL register all memory outputs: transfer at cycle N -> mem_we=1 at N+1 only, for one cycle per write.
REQ-015 Printable code 0x20..0x7E: SHALL write {bit7, code} to cursor_addr and advance the cursor by 1.
REQ-016 0x0D (CR): SHALL set cursor to column 0 of the current row, with no write.
REQ-017 0x0A (LF): SHALL set cursor to column 0 of the next row, with no write.
REQ-018 0x08 (BS): if column>0, SHALL decrement the cursor and write 0x20 at the new address; at column 0 SHALL do nothing.
REQ-019 0x0C (FF): SHALL enter CLEAR.
REQ-020 Any other code SHALL be accepted and ignored.
REQ-021 Advance past column 79 SHALL wrap to column 0 of the next row; advance or LF past row 33 SHALL wrap to cell 0, with no scrolling.
REQ-022 CLEAR SHALL write 0x20 to addresses 0..2719 in order, one per cycle, with busy=1.
REQ-023 After the write to address 2719, CLEAR SHALL go to IDLE with cursor_addr=0 and busy=0.
REQ-024 In CLEAR, in_ready SHALL be 0 and in_data SHALL be ignored.
REQ-025 cursor_addr SHALL update in the same cycle as the corresponding mem_we.
REQ-026 Arithmetic SHALL be 12-bit; cursor_addr SHALL never exceed 2719.

Reset
REQ-027 On reset, outputs SHALL take these values: mem_we=0, mem_addr=0, mem_wdata=0, cursor_addr=0.
REQ-028 Reset asserted mid-CLEAR SHALL abort the sweep and apply REQ-027 and REQ-029 on the next edge.
REQ-029 After reset, state and busy SHALL follow REQ-030/031.

Configuration
REQ-030 With VGA_TEXT_CONSOLE_CLEAR_ON_RESET_EN defined, reset SHALL enter CLEAR with busy=1 and in_ready=0, and a full 2720-cell sweep SHALL start on the first cycle after reset deasserts.
REQ-031 Without VGA_TEXT_CONSOLE_CLEAR_ON_RESET_EN, reset SHALL enter IDLE with busy=0 and in_ready=1, and RAM contents SHALL be left untouched.

Structure
REQ-032 Package vga_text_pkg SHALL hold:
- constants COLS=80, ROWS=34, CELLS=2720, BLANK=8'h20;
- control codes CR, LF, BS, FF;
- the FSM state enum.
REQ-033 A sub-module vga_text_cursor SHALL own the row, column and address counters, with advance, newline, home, back and wrap inputs.

Verification
REQ-034 Scenario 1: in_data 0x41 then 0xC2 in IDLE -> mem writes (0,0x41) then (1,0xC2); cursor_addr=2.
REQ-035 Scenario 2: cursor 79, send 0x58 -> write at addr 79; cursor_addr=80.
REQ-036 Scenario 3: cursor 2719, send 0x5A -> write at addr 2719; cursor_addr=0.
REQ-037 Scenario 4: cursor 163, send 0x0A -> cursor_addr=240, no write; then send 0x08 -> no write, cursor stays 240.
REQ-038 Scenario 5: send 0x0C -> exactly 2720 writes of 0x20 at addrs 0..2719, busy=1 throughout, in_ready=0; then cursor_addr=0.
REQ-039 Scenario 6: assert reset after 100 clear writes -> mem_we=0 next cycle; with the macro, a fresh sweep starts at addr 0; without it, IDLE and in_ready=1.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants, control codes and FSM state type for the 80x34 VGA text console.
package vga_text_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 34;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [6:0] CR = 7'h0D;
    localparam logic [6:0] LF = 7'h0A;
    localparam logic [6:0] BS = 7'h08;
    localparam logic [6:0] FF = 7'h0C;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20) && (code <= 7'h7E);
    endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Cursor position keeper: row, column and linear cell address (row*80+col), all kept in step.
module vga_text_cursor
    import vga_text_pkg::*;
(
    input  logic        clk25mhz,
    input  logic        reset,
    input  logic        advance_i,
    input  logic        newline_i,
    input  logic        home_i,
    input  logic        back_i,
    input  logic        wrap_i,
    output logic [6:0]  col_o,
    output logic [11:0] addr_o
);

    logic [5:0]  row_q,  row_d;
    logic [6:0]  col_q,  col_d;
    logic [11:0] addr_q, addr_d;

    logic last_col, last_row;

    assign last_col = (col_q == 7'(COLS - 1));
    assign last_row = (row_q == 6'(ROWS - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (wrap_i) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (advance_i) begin
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d  = '0;
                    addr_d = '0;
                end else begin
                    row_d  = row_q + 6'd1;
                    addr_d = addr_q + 12'd1;
                end
            end else begin
                col_d  = col_q + 7'd1;
                addr_d = addr_q + 12'd1;
            end
        end else if (newline_i) begin
            col_d = '0;
            if (last_row) begin
                row_d  = '0;
                addr_d = '0;
            end else begin
                row_d  = row_q + 6'd1;
                addr_d = addr_q - 12'(col_q) + 12'(COLS);
            end
        end else if (home_i) begin
            col_d  = '0;
            addr_d = addr_q - 12'(col_q);
        end else if (back_i && (col_q != 7'd0)) begin
            col_d  = col_q - 7'd1;
            addr_d = addr_q - 12'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign col_o  = col_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/vga_text_console.sv
// Host byte stream to character-RAM writer with cursor control and clear-screen sweep.
// Build option: VGA_TEXT_CONSOLE_CLEAR_ON_RESET_EN makes reset start a full clear sweep.
module vga_text_console
    import vga_text_pkg::*;
(
    input  logic        clk25mhz,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [11:0] cursor_addr,
    output logic        busy
);

    // The sweep counter holds the address currently on mem_addr; starting at all-ones
    // lets the first CLEAR cycle after reset wrap it to cell 0.
`ifdef VGA_TEXT_CONSOLE_CLEAR_ON_RESET_EN
    localparam state_e      RST_STATE = CLEAR;
    localparam logic [11:0] RST_CLR   = 12'hFFF;
`else
    localparam state_e      RST_STATE = IDLE;
    localparam logic [11:0] RST_CLR   = 12'd0;
`endif

    state_e      state_q, state_d;
    logic [11:0] clr_q, clr_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    logic        cur_advance, cur_newline, cur_home, cur_back, cur_wrap;
    logic [6:0]  cur_col;
    logic [11:0] cur_addr;
    logic [6:0]  code;
    logic        xfer;

    assign code     = in_data[6:0];
    assign in_ready = (state_q == IDLE);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cur_advance = 1'b0;
        cur_newline = 1'b0;
        cur_home    = 1'b0;
        cur_back    = 1'b0;
        cur_wrap    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (is_printable(code)) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cur_addr;
                        mem_wdata_d = in_data;
                        cur_advance = 1'b1;
                    end else if (code == CR) begin
                        cur_home = 1'b1;
                    end else if (code == LF) begin
                        cur_newline = 1'b1;
                    end else if (code == BS) begin
                        if (cur_col != 7'd0) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = cur_addr - 12'd1;
                            mem_wdata_d = BLANK;
                            cur_back    = 1'b1;
                        end
                    end else if (code == FF) begin
                        // First blank goes out with the same latency as a character write.
                        state_d     = CLEAR;
                        clr_d       = 12'd0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = 12'd0;
                        mem_wdata_d = BLANK;
                    end
                end
            end
            CLEAR: begin
                if (clr_q == 12'(CELLS - 1)) begin
                    state_d  = IDLE;
                    cur_wrap = 1'b1;
                end else begin
                    clr_d       = clr_q + 12'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = clr_q + 12'd1;
                    mem_wdata_d = BLANK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            state_q     <= RST_STATE;
            clr_q       <= RST_CLR;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    vga_text_cursor u_cursor (
        .clk25mhz  (clk25mhz),
        .reset     (reset),
        .advance_i (cur_advance),
        .newline_i (cur_newline),
        .home_i    (cur_home),
        .back_i    (cur_back),
        .wrap_i    (cur_wrap),
        .col_o     (cur_col),
        .addr_o    (cur_addr)
    );

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cursor_addr = cur_addr;
    assign busy        = (state_q == CLEAR);

endmodule
